trivium_decrypt: RTL and testbench
==================================

TRIVIUM_DECRYPT -- requirements
Module: trivium_decrypt

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: key_bit  in  1  serial key bit, K1 first.
REQ-004 SHALL have: key_vld  in  1  key_bit qualifier, held high for 80 consecutive cycles.
REQ-005 SHALL have: iv  in  80  IV, IV1 = iv[79], sampled on the cycle the 80th key bit is taken.
REQ-006 SHALL have: ct_data  in  8  ciphertext byte.
REQ-007 SHALL have: ct_valid  in  1 and ct_ready  out  1  input valid/ready handshake.
REQ-008 SHALL have: pt_data  out  8 and pt_valid  out  1 and pt_ready  in  1  output valid/ready handshake.
REQ-009 SHALL have: running  out  1  high in RUN state.
REQ-010 SHALL have: key_err  out  1  one-cycle pulse, short key.
REQ-011 SHALL have: frame_done  out  1  one-cycle pulse, 256th byte of a frame accepted.

Function
REQ-012 SHALL implement states IDLE, LOAD_KEY, INIT, RUN.
REQ-013 IDLE: key_vld=1 -> LOAD_KEY, bit captured, key_cnt=1; ct/pt inactive.
REQ-014 LOAD_KEY: each key_vld=1 cycle shifts key_bit in, key_cnt+1; on the 80th bit -> INIT, state loaded.
REQ-015 LOAD_KEY: key_vld=0 with key_cnt<80 -> key_err pulse, key_cnt=0, -> IDLE.
REQ-016 State load: s1..s80=K1..K80, s81..s93=0; s94..s173=IV1..IV80, s174..s177=0; s178..s285=0, s286..s288=1.
REQ-017 Update per bit: t1=s66^s93, t2=s162^s177, t3=s243^s288; z=t1^t2^t3; t1^=s91&s92^s171; t2^=s175&s176^s264; t3^=s286&s287^s69; rotate, s1=t3, s94=t1, s178=t2.
REQ-018 Core SHALL advance exactly 8 bits per step; first bit generated maps to z[0] (LSB).
REQ-019 INIT: one step per cycle, no z output, 144 cycles (1152 bits), then -> RUN; running=1 from the following cycle.
REQ-020 RUN: ct_ready = !pt_valid | pt_ready (combinational).
REQ-021 Byte accepted when ct_valid&ct_ready: next cycle pt_data=ct_data^z, pt_valid=1, core steps once; latency 1 cycle.
REQ-022 Keystream SHALL advance only on accepted bytes; stalls hold state unchanged.
REQ-023 pt_valid&!pt_ready: pt_data/pt_valid held stable; pt_valid clears on pt_ready unless a new byte is accepted in the same cycle (back-to-back, full throughput).
REQ-024 byte_cnt 8-bit, increments per accepted byte, wraps 255->0; frame_done pulses the cycle after the 256th acceptance; decryption continues without resync.
REQ-025 key_vld=1 in INIT or RUN: abort, pt_valid=0, byte_cnt=0, capture bit, key_cnt=1, -> LOAD_KEY (rekey).
REQ-026 ct_valid outside RUN SHALL be ignored (ct_ready=0).

Reset
REQ-027 rst=1 at a clock edge: state IDLE, key_cnt=0, byte_cnt=0, Trivium state=0, pt_data=0, pt_valid=0, running=0, key_err=0, frame_done=0, ct_ready=0.
REQ-028 rst SHALL take precedence over every other input, including mid-INIT and mid-transfer.

Structure
REQ-029 Package trivium_pkg SHALL hold KEY_W=80, IV_W=80, INIT_STEPS=144, FRAME_LEN=256, STEP_W=8 and the state enum.
REQ-030 Sub-module trivium_core SHALL hold the 288-bit state, load and 8-bit step logic, z[7:0] output; it is shared with the encryptor.

Verification
REQ-031 Key/IV all-zero, 80-bit key load, 144-cycle wait -> running rises exactly 80+144+1 cycles after first key_vld; pt bytes equal golden C model.
REQ-032 Round trip: encryptor output for 512 random bytes fed in -> pt equals original plaintext; frame_done pulses exactly twice.
REQ-033 pt_ready held 0 for 10 cycles with ct_valid=1 -> one pt byte stable, ct_ready=0, no keystream advance; resume yields byte-exact golden sequence.
REQ-034 key_vld dropped after 40 bits -> key_err one-cycle pulse, state IDLE, running=0.
REQ-035 rst asserted at INIT cycle 70 and during RUN byte 100 -> all outputs reset next cycle; full reload reproduces golden stream from byte 0.
REQ-036 key_vld asserted during RUN -> pt_valid=0, byte_cnt=0, new key applied, stream matches model for new key.

Source files
------------

// File: rtl/trivium_pkg.sv
// Shared Trivium constants, the decryptor state encoding and the 288-bit
// state image built from a key/IV pair.
package trivium_pkg;

    localparam int KEY_W      = 80;
    localparam int IV_W       = 80;
    localparam int INIT_STEPS = 144;
    localparam int FRAME_LEN  = 256;
    localparam int STEP_W     = 8;
    localparam int STATE_W    = 288;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_KEY,
        ST_INIT,
        ST_RUN
    } state_t;

    // Element 1 of the returned vector is s1 (the MSB), so K1 = key[79] and IV1 = iv[79].
    function automatic logic [1:STATE_W] load_state(input logic [KEY_W-1:0] key,
                                                     input logic [IV_W-1:0]  iv);
        return {key, 13'b0, iv, 4'b0, 108'b0, 3'b111};
    endfunction

endpackage

// File: rtl/trivium_core.sv
// Trivium keystream core: 288-bit state, key/IV load and an 8-bit-per-step
// update. o_z is the keystream byte the next step will consume, bit 0 first.
module trivium_core
    import trivium_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [KEY_W-1:0]  i_key,
    input  logic [IV_W-1:0]   i_iv,
    input  logic              i_step,
    output logic [STEP_W-1:0] o_z
);

    logic [1:STATE_W] r_state;
    logic [1:STATE_W] w_state_next;

    always_comb begin : step_logic
        logic w_t1;
        logic w_t2;
        logic w_t3;
        w_state_next = r_state;
        o_z          = '0;
        w_t1         = 1'b0;
        w_t2         = 1'b0;
        w_t3         = 1'b0;
        for (int i = 0; i < STEP_W; i++) begin
            w_t1   = w_state_next[66]  ^ w_state_next[93];
            w_t2   = w_state_next[162] ^ w_state_next[177];
            w_t3   = w_state_next[243] ^ w_state_next[288];
            o_z[i] = w_t1 ^ w_t2 ^ w_t3;
            w_t1   = w_t1 ^ (w_state_next[91]  & w_state_next[92])  ^ w_state_next[171];
            w_t2   = w_t2 ^ (w_state_next[175] & w_state_next[176]) ^ w_state_next[264];
            w_t3   = w_t3 ^ (w_state_next[286] & w_state_next[287]) ^ w_state_next[69];
            // Three shift registers rotate together; feedback enters at s1, s94, s178.
            w_state_next = {w_t3, w_state_next[1:92],
                            w_t1, w_state_next[94:176],
                            w_t2, w_state_next[178:287]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= load_state(i_key, i_iv);
        end else if (i_step) begin
            r_state <= w_state_next;
        end
    end

endmodule

// File: rtl/trivium_decrypt.sv
// Streaming Trivium decryptor: serial key load, 1152-bit warm-up, then one
// keystream byte XORed per accepted ciphertext byte with valid/ready flow control.
module trivium_decrypt
    import trivium_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            key_bit,
    input  logic            key_vld,
    input  logic [IV_W-1:0] iv,
    input  logic [7:0]      ct_data,
    input  logic            ct_valid,
    output logic            ct_ready,
    output logic [7:0]      pt_data,
    output logic            pt_valid,
    input  logic            pt_ready,
    output logic            running,
    output logic            key_err,
    output logic            frame_done
);

    state_t            r_state;
    state_t            w_next;
    logic [KEY_W-2:0]  r_key;
    logic [6:0]        r_key_cnt;
    logic [7:0]        r_init_cnt;
    logic [7:0]        r_byte_cnt;
    logic [7:0]        r_pt_data;
    logic              r_pt_valid;
    logic              r_running;
    logic              r_key_err;
    logic              r_frame_done;

    logic              w_ct_ready;
    logic              w_accept;
    logic              w_core_load;
    logic              w_core_step;
    logic              w_rekey;
    logic [STEP_W-1:0] w_z;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (key_vld) w_next = ST_LOAD_KEY;
            ST_LOAD_KEY: begin
                if (!key_vld) begin
                    w_next = ST_IDLE;
                end else if (r_key_cnt == 7'(KEY_W - 1)) begin
                    w_next = ST_INIT;
                end
            end
            ST_INIT: begin
                if (key_vld) begin
                    w_next = ST_LOAD_KEY;
                end else if (r_init_cnt == 8'(INIT_STEPS - 1)) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN:      if (key_vld) w_next = ST_LOAD_KEY;
            default:     w_next = ST_IDLE;
        endcase
    end

    // ct_ready also drops while a rekey is requested so a byte is never reported taken and dropped.
    always_comb begin
        w_rekey     = key_vld && (r_state == ST_INIT || r_state == ST_RUN);
        w_ct_ready  = r_running && !key_vld && (!r_pt_valid || pt_ready);
        w_accept    = w_ct_ready && ct_valid;
        w_core_load = (r_state == ST_LOAD_KEY) && key_vld && (r_key_cnt == 7'(KEY_W - 1));
        w_core_step = (r_state == ST_INIT) || w_accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key        <= '0;
            r_key_cnt    <= '0;
            r_init_cnt   <= '0;
            r_byte_cnt   <= '0;
            r_pt_data    <= '0;
            r_pt_valid   <= 1'b0;
            r_running    <= 1'b0;
            r_key_err    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_key_err    <= 1'b0;
            r_frame_done <= 1'b0;
            // running rises on the second RUN cycle and falls together with any abort.
            r_running    <= (r_state == ST_RUN) && (w_next == ST_RUN);
            r_init_cnt   <= (r_state == ST_INIT) ? r_init_cnt + 8'd1 : 8'd0;

            if (key_vld) begin
                r_key     <= {r_key[KEY_W-3:0], key_bit};
                r_key_cnt <= (r_state == ST_LOAD_KEY) ? r_key_cnt + 7'd1 : 7'd1;
            end else if (r_state == ST_LOAD_KEY) begin
                r_key_err <= 1'b1;
                r_key_cnt <= '0;
            end

            if (w_rekey) begin
                r_pt_valid <= 1'b0;
                r_byte_cnt <= '0;
            end else if (w_accept) begin
                r_pt_data    <= ct_data ^ w_z;
                r_pt_valid   <= 1'b1;
                r_byte_cnt   <= r_byte_cnt + 8'd1;
                r_frame_done <= (r_byte_cnt == 8'(FRAME_LEN - 1));
            end else if (pt_ready) begin
                r_pt_valid <= 1'b0;
            end
        end
    end

    trivium_core u_core (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_core_load),
        .i_key  ({r_key, key_bit}),
        .i_iv   (iv),
        .i_step (w_core_step),
        .o_z    (w_z)
    );

    assign ct_ready   = w_ct_ready;
    assign pt_data    = r_pt_data;
    assign pt_valid   = r_pt_valid;
    assign running    = r_running;
    assign key_err    = r_key_err;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_trivium_decrypt.sv
// Scoreboard bench for trivium_decrypt: stimulus pushes expected plaintext
// from a bit-serial reference model, a negedge monitor pops and compares.
module tb_trivium_decrypt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_bit = 1'b0;
    logic        key_vld = 1'b0;
    logic [79:0] iv = '0;
    logic [7:0]  ct_data = '0;
    logic        ct_valid = 1'b0;
    logic        ct_ready;
    logic [7:0]  pt_data;
    logic        pt_valid;
    logic        pt_ready = 1'b1;
    logic        running;
    logic        key_err;
    logic        frame_done;

    always #5 clk = ~clk;

    trivium_decrypt dut (
        .clk        (clk),
        .rst        (rst),
        .key_bit    (key_bit),
        .key_vld    (key_vld),
        .iv         (iv),
        .ct_data    (ct_data),
        .ct_valid   (ct_valid),
        .ct_ready   (ct_ready),
        .pt_data    (pt_data),
        .pt_valid   (pt_valid),
        .pt_ready   (pt_ready),
        .running    (running),
        .key_err    (key_err),
        .frame_done (frame_done)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         frame_pulses = 0;
    int         accepted = 0;
    int         pt_seen = 0;
    logic [7:0] exp_q[$];
    bit         m_s[1:288];
    bit         have_byte = 1'b0;
    logic [7:0] cur_p;
    bit         hold_prev = 1'b0;
    logic [7:0] prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference Trivium, one bit per call, written from the textbook recurrence.
    function automatic bit m_bit();
        bit t1, t2, t3, z;
        t1 = m_s[66] ^ m_s[93];
        t2 = m_s[162] ^ m_s[177];
        t3 = m_s[243] ^ m_s[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (m_s[91] & m_s[92]) ^ m_s[171];
        t2 = t2 ^ (m_s[175] & m_s[176]) ^ m_s[264];
        t3 = t3 ^ (m_s[286] & m_s[287]) ^ m_s[69];
        for (int i = 288; i > 1; i--) m_s[i] = m_s[i-1];
        m_s[1]   = t3;
        m_s[94]  = t1;
        m_s[178] = t2;
        return z;
    endfunction

    function automatic logic [7:0] m_byte();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = m_bit();
        return b;
    endfunction

    function automatic void m_load(input logic [79:0] k, input logic [79:0] v);
        for (int i = 1; i <= 288; i++) m_s[i] = 1'b0;
        for (int i = 1; i <= 80; i++) m_s[i] = k[80-i];
        for (int i = 94; i <= 173; i++) m_s[i] = v[173-i];
        m_s[286] = 1'b1;
        m_s[287] = 1'b1;
        m_s[288] = 1'b1;
        for (int i = 0; i < 1152; i++) void'(m_bit());
    endfunction

    // Monitor: sees the same handshake values the next rising edge will sample.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_pt_valid", pt_valid, 1);
                check("hold_pt_data", pt_data, prev_data);
            end
            if (pt_valid && pt_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pt_unexpected: got %02h, expected no byte", pt_data);
                end else begin
                    e = exp_q.pop_front();
                    pt_seen++;
                    $display("pt %0d: got %02h expected %02h", pt_seen, pt_data, e);
                    check("pt_data", pt_data, e);
                end
            end
            hold_prev = pt_valid && !pt_ready;
            prev_data = pt_data;
            if (frame_done) frame_pulses++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of ciphertext traffic; keystream is drawn once per new byte.
    task automatic cycle(input bit want, input bit rdy);
        if (want && !have_byte) begin
            cur_p     = 8'($urandom);
            ct_data   = cur_p ^ m_byte();
            have_byte = 1'b1;
        end
        ct_valid = want;
        pt_ready = rdy;
        @(negedge clk);
        if (ct_valid && ct_ready) begin
            exp_q.push_back(cur_p);
            have_byte = 1'b0;
            accepted++;
        end
        tick();
    endtask

    task automatic stream(input int count, input bit rnd, input bit drain);
        int start = accepted;
        int guard = 0;
        while (accepted - start < count && guard < count * 8 + 100) begin
            cycle(1'b1, rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            guard++;
        end
        check("stream_bytes_accepted", accepted - start, count);
        if (drain) begin
            repeat (4) cycle(1'b0, 1'b1);
            check("stream_drained", exp_q.size(), 0);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        key_vld  = 1'b0;
        ct_valid = 1'b0;
        pt_ready = 1'b1;
        tick();
        exp_q.delete();
        have_byte = 1'b0;
        check("rst_pt_valid", pt_valid, 0);
        check("rst_pt_data", pt_data, 0);
        check("rst_running", running, 0);
        check("rst_ct_ready", ct_ready, 0);
        check("rst_key_err", key_err, 0);
        check("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        tick();
    endtask

    // abort_at >= 0 asserts reset at that INIT cycle instead of waiting for RUN.
    task automatic load_key(input logic [79:0] k, input logic [79:0] v,
                            input bit chk_timing, input bit chk_abort, input int abort_at);
        int n = 0;
        ct_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            key_vld = 1'b1;
            key_bit = k[79-i];
            iv      = v;
            tick();
            if (i == 0 && chk_abort) begin
                check("rekey_pt_valid", pt_valid, 0);
                check("rekey_running", running, 0);
            end
        end
        key_vld = 1'b0;
        key_bit = 1'b0;
        exp_q.delete();
        have_byte = 1'b0;
        m_load(k, v);
        while (!running && n < 400) begin
            if (n == abort_at) begin
                do_reset();
                return;
            end
            tick();
            n++;
        end
        check("running_rise", running, 1);
        if (chk_timing) check("running_latency", n, 145);
    endtask

    localparam logic [79:0] KEY_B = 80'h0123_4567_89AB_CDEF_0123;
    localparam logic [79:0] IV_B  = 80'hFEDC_BA98_7654_3210_A5A5;
    localparam logic [79:0] KEY_C = 80'h8000_0000_0000_0000_0001;
    localparam logic [79:0] IV_C  = 80'h0000_0000_0000_0000_0001;
    localparam logic [79:0] KEY_D = 80'h5A5A_1234_C3C3_9876_F00F;
    localparam logic [79:0] IV_D  = 80'h1111_2222_3333_4444_5555;

    initial begin
        int a0;
        tick();
        do_reset();

        // All-zero key/IV: running latency and golden stream.
        load_key('0, '0, 1'b1, 1'b0, -1);
        stream(64, 1'b0, 1'b1);

        // Output stall: one byte parked, ct_ready low, keystream frozen.
        cycle(1'b1, 1'b0);
        a0 = accepted;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0);
            check("stall_ct_ready", ct_ready, 0);
        end
        check("stall_no_accept", accepted, a0);
        stream(30, 1'b0, 1'b1);

        // Short key: 40 bits then key_vld drops.
        for (int i = 0; i < 40; i++) begin
            key_vld = 1'b1;
            key_bit = i[0];
            tick();
        end
        key_vld = 1'b0;
        tick();
        check("short_key_err", key_err, 1);
        check("short_running", running, 0);
        tick();
        check("short_key_err_pulse", key_err, 0);
        check("short_ct_ready", ct_ready, 0);

        // Round trip over two frames with random output back-pressure.
        frame_pulses = 0;
        load_key(KEY_B, IV_B, 1'b1, 1'b0, -1);
        stream(512, 1'b1, 1'b1);
        check("frame_done_count_512", frame_pulses, 2);

        // Reset mid-INIT, reload, reset mid-RUN, reload: stream restarts at byte 0.
        load_key(KEY_C, IV_C, 1'b0, 1'b0, 70);
        load_key(KEY_C, IV_C, 1'b0, 1'b0, -1);
        stream(100, 1'b0, 1'b0);
        do_reset();
        load_key(KEY_C, IV_C, 1'b0, 1'b0, -1);
        stream(40, 1'b0, 1'b1);

        // Rekey while running: byte counter restarts with the new key.
        stream(20, 1'b0, 1'b0);
        load_key(KEY_D, IV_D, 1'b0, 1'b1, -1);
        frame_pulses = 0;
        stream(250, 1'b0, 1'b1);
        check("frame_done_after_250", frame_pulses, 0);
        stream(6, 1'b0, 1'b1);
        check("frame_done_after_256", frame_pulses, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
